control_unit: RTL and testbench

Microcode sequencer for the 8-bit bus CPU. It steps through fetch and execute micro-steps and drives the load and bus-enable strobes of every `register` instance, the program counter, RAM/MAR, ALU, flags and output register. It is the single arbiter of the shared 8-bit bus, so exactly one or zero bus drivers is enabled per cycle. It sits between the instruction register (opcode nibble) and all datapath blocks.

---
 rtl/control_unit_pkg.sv | 43 ++++
 rtl/control_unit_if.sv | 29 ++
 rtl/control_unit_microcode_rom.sv | 59 +++++
 rtl/control_unit.sv | 70 +++++++
 tb/tb_control_unit.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/control_unit_pkg.sv
// Shared encodings for the 8-bit bus CPU sequencer: opcodes, step widths and
// control-word bit positions.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int STEP_W = 3;
  localparam logic [STEP_W-1:0] LAST_STEP = 3'd4;
  localparam logic [STEP_W-1:0] HLT_STEP  = 3'd2;

  // Control word: bus drivers in the low five bits, loads/controls above.
  localparam int CW_W  = 15;
  localparam int CW_CO = 0;
  localparam int CW_RO = 1;
  localparam int CW_IO = 2;
  localparam int CW_AO = 3;
  localparam int CW_EO = 4;
  localparam int CW_MI = 5;
  localparam int CW_RI = 6;
  localparam int CW_II = 7;
  localparam int CW_AI = 8;
  localparam int CW_BI = 9;
  localparam int CW_OI = 10;
  localparam int CW_CE = 11;
  localparam int CW_J  = 12;
  localparam int CW_SU = 13;
  localparam int CW_FI = 14;

  function automatic logic [CW_W-1:0] cw_bit(input int idx);
    return CW_W'(1) << idx;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit boundary: step enable, opcode and flags in; step, halt and all
// datapath strobes out.
interface control_unit_if;
  import cpu_pkg::*;

  logic              i_enable;
  logic [3:0]        i_opcode;
  logic              i_flag_c;
  logic              i_flag_z;
  logic [STEP_W-1:0] o_step;
  logic              o_hlt;
  logic              o_co, o_ro, o_io, o_ao, o_eo;
  logic              o_mi, o_ri, o_ii, o_ai, o_bi, o_oi, o_ce, o_j, o_su, o_fi;

  modport master (
    input  i_enable, i_opcode, i_flag_c, i_flag_z,
    output o_step, o_hlt,
    output o_co, o_ro, o_io, o_ao, o_eo,
    output o_mi, o_ri, o_ii, o_ai, o_bi, o_oi, o_ce, o_j, o_su, o_fi
  );

  modport slave (
    output i_enable, i_opcode, i_flag_c, i_flag_z,
    input  o_step, o_hlt,
    input  o_co, o_ro, o_io, o_ao, o_eo,
    input  o_mi, o_ri, o_ii, o_ai, o_bi, o_oi, o_ce, o_j, o_su, o_fi
  );

endinterface

// File: rtl/control_unit_microcode_rom.sv
// Combinational microcode table: control word and instruction length for a
// given opcode, micro-step and flag state.
module microcode_rom
  import cpu_pkg::*;
(
  input  logic [3:0]        i_opcode,
  input  logic [STEP_W-1:0] i_step,
  input  logic              i_flag_c,
  input  logic              i_flag_z,
  output logic [CW_W-1:0]   o_cw,
  output logic [STEP_W-1:0] o_len
);

  always_comb begin
    o_len = 3'd2;
    case (i_opcode)
      OP_LDA, OP_STA:                                o_len = 3'd4;
      OP_ADD, OP_SUB:                                o_len = 3'd5;
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: o_len = 3'd3;
      default:                                       o_len = 3'd2;
    endcase
  end

  always_comb begin
    o_cw = '0;
    case (i_step)
      3'd0: o_cw = cw_bit(CW_CO) | cw_bit(CW_MI);
      3'd1: o_cw = cw_bit(CW_RO) | cw_bit(CW_II) | cw_bit(CW_CE);
      3'd2: begin
        case (i_opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: o_cw = cw_bit(CW_IO) | cw_bit(CW_MI);
          OP_LDI: o_cw = cw_bit(CW_IO) | cw_bit(CW_AI);
          OP_JMP: o_cw = cw_bit(CW_IO) | cw_bit(CW_J);
          OP_JC:  o_cw = i_flag_c ? (cw_bit(CW_IO) | cw_bit(CW_J)) : '0;
          OP_JZ:  o_cw = i_flag_z ? (cw_bit(CW_IO) | cw_bit(CW_J)) : '0;
          OP_OUT: o_cw = cw_bit(CW_AO) | cw_bit(CW_OI);
          default: o_cw = '0;
        endcase
      end
      3'd3: begin
        case (i_opcode)
          OP_LDA:         o_cw = cw_bit(CW_RO) | cw_bit(CW_AI);
          OP_ADD, OP_SUB: o_cw = cw_bit(CW_RO) | cw_bit(CW_BI);
          OP_STA:         o_cw = cw_bit(CW_AO) | cw_bit(CW_RI);
          default:        o_cw = '0;
        endcase
      end
      3'd4: begin
        case (i_opcode)
          OP_ADD:  o_cw = cw_bit(CW_EO) | cw_bit(CW_AI) | cw_bit(CW_FI);
          OP_SUB:  o_cw = cw_bit(CW_EO) | cw_bit(CW_AI) | cw_bit(CW_FI) | cw_bit(CW_SU);
          default: o_cw = '0;
        endcase
      end
      default: o_cw = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Microcode sequencer: step counter and sticky halt, with enable/reset gating
// of the strobes and sole ownership of the shared bus.
module control_unit
  import cpu_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst,
  control_unit_if.master bus
);

  logic [STEP_W-1:0] r_step;
  logic              r_halted;

  logic [CW_W-1:0]   w_cw;
  logic [CW_W-1:0]   w_cw_gated;
  logic [STEP_W-1:0] w_len;
  logic [STEP_W-1:0] w_next;
  logic              w_run;
  logic              w_hlt_step;

  microcode_rom u_rom (
    .i_opcode (bus.i_opcode),
    .i_step   (r_step),
    .i_flag_c (bus.i_flag_c),
    .i_flag_z (bus.i_flag_z),
    .o_cw     (w_cw),
    .o_len    (w_len)
  );

  assign w_run      = bus.i_enable & ~r_halted;
  assign w_hlt_step = (bus.i_opcode == OP_HLT) && (r_step == HLT_STEP);

  // Short instructions wrap straight back to fetch; LAST_STEP is a hard cap.
  assign w_next = ((r_step + 3'd1) >= w_len || r_step == LAST_STEP) ? '0 : r_step + 3'd1;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_step   <= '0;
      r_halted <= 1'b0;
    end else if (w_run) begin
      if (w_hlt_step) r_halted <= 1'b1;
      else            r_step   <= w_next;
    end
  end

  assign w_cw_gated = (i_rst && w_run) ? w_cw : '0;

  assign bus.o_step = r_step;
  assign bus.o_hlt  = i_rst & (r_halted | (w_hlt_step & bus.i_enable));

  assign bus.o_co = w_cw_gated[CW_CO];
  assign bus.o_ro = w_cw_gated[CW_RO];
  assign bus.o_io = w_cw_gated[CW_IO];
  assign bus.o_ao = w_cw_gated[CW_AO];
  assign bus.o_eo = w_cw_gated[CW_EO];
  assign bus.o_mi = w_cw_gated[CW_MI];
  assign bus.o_ri = w_cw_gated[CW_RI];
  assign bus.o_ii = w_cw_gated[CW_II];
  assign bus.o_ai = w_cw_gated[CW_AI];
  assign bus.o_bi = w_cw_gated[CW_BI];
  assign bus.o_oi = w_cw_gated[CW_OI];
  assign bus.o_ce = w_cw_gated[CW_CE];
  assign bus.o_j  = w_cw_gated[CW_J];
  assign bus.o_su = w_cw_gated[CW_SU];
  assign bus.o_fi = w_cw_gated[CW_FI];

  a_bus_onehot: assert property (@(posedge i_clk) disable iff (!i_rst)
    $onehot0({bus.o_co, bus.o_ro, bus.o_io, bus.o_ao, bus.o_eo}));

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a cycle model pushes expected outputs,
// which are popped and compared against the sampled DUT every cycle.
module tb_control_unit;

  localparam logic [14:0] CO = 15'b100000000000000;
  localparam logic [14:0] RO = 15'b010000000000000;
  localparam logic [14:0] IO = 15'b001000000000000;
  localparam logic [14:0] AO = 15'b000100000000000;
  localparam logic [14:0] EO = 15'b000010000000000;
  localparam logic [14:0] MI = 15'b000001000000000;
  localparam logic [14:0] RI = 15'b000000100000000;
  localparam logic [14:0] II = 15'b000000010000000;
  localparam logic [14:0] AI = 15'b000000001000000;
  localparam logic [14:0] BI = 15'b000000000100000;
  localparam logic [14:0] OI = 15'b000000000010000;
  localparam logic [14:0] CE = 15'b000000000001000;
  localparam logic [14:0] JJ = 15'b000000000000100;
  localparam logic [14:0] SU = 15'b000000000000010;
  localparam logic [14:0] FI = 15'b000000000000001;

  typedef struct packed {
    logic [2:0]  step;
    logic        hlt;
    logic [14:0] cw;
  } exp_t;

  logic clk;
  logic rst_n;
  control_unit_if bus_if ();

  control_unit dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [2:0] m_step;
  logic       m_halted;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] ilen(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 3'd4;
      4'h2, 4'h3: return 3'd5;
      4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF: return 3'd3;
      default: return 3'd2;
    endcase
  endfunction

  function automatic logic [14:0] exp_cw(input logic [3:0] op, input logic [2:0] st,
                                          input logic c, input logic z);
    case (st)
      3'd0: return CO | MI;
      3'd1: return RO | II | CE;
      3'd2: case (op)
              4'h1, 4'h2, 4'h3, 4'h4: return IO | MI;
              4'h5: return IO | AI;
              4'h6: return IO | JJ;
              4'h7: return c ? (IO | JJ) : 15'd0;
              4'h8: return z ? (IO | JJ) : 15'd0;
              4'hE: return AO | OI;
              default: return 15'd0;
            endcase
      3'd3: case (op)
              4'h1: return RO | AI;
              4'h2, 4'h3: return RO | BI;
              4'h4: return AO | RI;
              default: return 15'd0;
            endcase
      3'd4: case (op)
              4'h2: return EO | AI | FI;
              4'h3: return EO | AI | FI | SU;
              default: return 15'd0;
            endcase
      default: return 15'd0;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    if (rst_n) begin
      e.step = m_step;
      e.hlt  = m_halted | (bus_if.i_opcode == 4'hF && m_step == 3'd2 && bus_if.i_enable);
      e.cw   = (bus_if.i_enable && !m_halted)
               ? exp_cw(bus_if.i_opcode, m_step, bus_if.i_flag_c, bus_if.i_flag_z) : 15'd0;
    end
    return e;
  endfunction

  function automatic logic [14:0] dut_cw();
    return {bus_if.o_co, bus_if.o_ro, bus_if.o_io, bus_if.o_ao, bus_if.o_eo,
            bus_if.o_mi, bus_if.o_ri, bus_if.o_ii, bus_if.o_ai, bus_if.o_bi,
            bus_if.o_oi, bus_if.o_ce, bus_if.o_j,  bus_if.o_su, bus_if.o_fi};
  endfunction

  task automatic model_advance();
    if (!rst_n) begin
      m_step   = 3'd0;
      m_halted = 1'b0;
    end else if (bus_if.i_enable && !m_halted) begin
      if (bus_if.i_opcode == 4'hF && m_step == 3'd2) m_halted = 1'b1;
      else if (m_step == ilen(bus_if.i_opcode) - 3'd1) m_step = 3'd0;
      else m_step = m_step + 3'd1;
    end
  endtask

  task automatic check_now(input string tag);
    exp_t e;
    sb.push_back(model_out());
    e = sb.pop_front();
    chk({tag, ".step"}, 32'(bus_if.o_step), 32'(e.step));
    chk({tag, ".hlt"},  32'(bus_if.o_hlt),  32'(e.hlt));
    chk({tag, ".cw"},   32'(dut_cw()),      32'(e.cw));
    chk({tag, ".bus1hot"},
        32'($onehot0({bus_if.o_co, bus_if.o_ro, bus_if.o_io, bus_if.o_ao, bus_if.o_eo})), 32'd1);
  endtask

  // Called just after a falling edge with inputs already set.
  task automatic cycle(input string tag);
    #1;
    check_now(tag);
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic run(input string tag, input logic [3:0] op, input int n,
                     input logic c, input logic z, input logic en);
    bus_if.i_opcode = op;
    bus_if.i_flag_c = c;
    bus_if.i_flag_z = z;
    bus_if.i_enable = en;
    repeat (n) cycle(tag);
  endtask

  task automatic abort(input string tag);
    #2;
    rst_n = 1'b0;
    m_step   = 3'd0;
    m_halted = 1'b0;
    #1;
    check_now(tag);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    m_step   = 3'd0;
    m_halted = 1'b0;
    rst_n    = 1'b0;
    bus_if.i_enable = 1'b1;
    bus_if.i_opcode = 4'h5;
    bus_if.i_flag_c = 1'b0;
    bus_if.i_flag_z = 1'b0;

    run("reset", 4'h5, 3, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;

    run("ldi",   4'h5, 3, 1'b0, 1'b0, 1'b1);
    run("sub",   4'h3, 5, 1'b0, 1'b0, 1'b1);
    run("lda",   4'h1, 4, 1'b0, 1'b0, 1'b1);
    run("add",   4'h2, 5, 1'b1, 1'b1, 1'b1);
    run("sta",   4'h4, 4, 1'b0, 1'b0, 1'b1);
    run("jmp",   4'h6, 3, 1'b0, 1'b0, 1'b1);
    run("jc0",   4'h7, 3, 1'b0, 1'b1, 1'b1);
    run("jc1",   4'h7, 3, 1'b1, 1'b0, 1'b1);
    run("jz0",   4'h8, 3, 1'b1, 1'b0, 1'b1);
    run("jz1",   4'h8, 3, 1'b0, 1'b1, 1'b1);
    run("out",   4'hE, 3, 1'b0, 1'b0, 1'b1);
    run("nop",   4'h0, 2, 1'b0, 1'b0, 1'b1);
    run("undef", 4'hA, 2, 1'b1, 1'b1, 1'b1);

    run("stall_pre",  4'h2, 3, 1'b0, 1'b0, 1'b1);
    run("stall",      4'h2, 3, 1'b0, 1'b0, 1'b0);
    run("stall_post", 4'h2, 2, 1'b0, 1'b0, 1'b1);

    run("abort_pre", 4'h2, 3, 1'b0, 1'b0, 1'b1);
    abort("abort");
    run("refetch",   4'h5, 3, 1'b0, 1'b0, 1'b1);

    run("hlt_pre",   4'hF, 2, 1'b0, 1'b0, 1'b1);
    run("hlt_stall", 4'hF, 2, 1'b0, 1'b0, 1'b0);
    run("hlt",       4'hF, 22, 1'b1, 1'b1, 1'b1);
    run("hlt_sticky",4'h5, 3, 1'b0, 1'b0, 1'b1);
    abort("hlt_clear");
    run("post_hlt",  4'h5, 3, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
